// File: rtl/deserializer.sv
// deserializer: receive-side serial-to-parallel converter.
// It collects an LSB-first serial stream into LENGTH-bit words. A frame
// begins on the bit that arrives together with i_start. Each completed word
// is presented on ov_dout with a single-cycle o_dout_valid pulse.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_en          clock enable; 0 holds all state and ignores i_din/i_start
//   i_start       current i_din is bit 0 of a new frame
//   i_din         serial data bit, LSB first
//   ov_dout       last completed word (registered, held until next completion)
//   o_dout_valid  1-cycle pulse: ov_dout updated this cycle
//   o_busy        1 while a frame is partially received
//   o_abort       1-cycle pulse: partial frame discarded by a restart
module deserializer #(
  parameter int LENGTH = 24
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_start,
  input  logic              i_din,
  output logic [LENGTH-1:0] ov_dout,
  output logic              o_dout_valid,
  output logic              o_busy,
  output logic              o_abort
);

  localparam int CNT_W = $clog2(LENGTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LENGTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LENGTH-1:0] shift_q, shift_d;
  logic [LENGTH-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              abort_q, abort_d;

  // Next-state, bit assembly and output pulse generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    abort_d = 1'b0;
    if (i_en) begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            // The shift register is cleared at frame start so later bits can
            // simply be OR-ed into their position.
            shift_d = LENGTH'(i_din);
            if (LENGTH == 1) begin
              dout_d  = LENGTH'(i_din);
              valid_d = 1'b1;
              cnt_d   = {CNT_W{1'b0}};
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = SHIFT;
            end
          end else begin
            state_d = IDLE;
          end
        end
        SHIFT: begin
          if (i_start) begin
            // Restart: the current bit becomes bit 0 of the new frame.
            shift_d = LENGTH'(i_din);
            cnt_d   = CNT_W'(1);
            abort_d = 1'b1;
          end else begin
            shift_d = shift_q | (LENGTH'(i_din) << cnt_q);
            if (cnt_q == LAST_IDX) begin
              dout_d  = shift_q | (LENGTH'(i_din) << cnt_q);
              valid_d = 1'b1;
              cnt_d   = {CNT_W{1'b0}};
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d == SHIFT);
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      shift_q <= {LENGTH{1'b0}};
      dout_q  <= {LENGTH{1'b0}};
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      abort_q <= abort_d;
    end
  end

  assign ov_dout      = dout_q;
  assign o_dout_valid = valid_q;
  assign o_busy       = busy_q;
  assign o_abort      = abort_q;

endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: randomized scoreboard bench for deserializer (LENGTH=24).
// The driver feeds bits into a reference model that keeps the received bits
// of the current frame in a queue; completed words and restarts push
// expectations (value and cycle) that a negedge monitor pops and compares.
module tb_deserializer;

  localparam int LENGTH = 24;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_en = 1'b0;
  logic              i_start = 1'b0;
  logic              i_din = 1'b0;
  logic [LENGTH-1:0] ov_dout;
  logic              o_dout_valid;
  logic              o_busy;
  logic              o_abort;

  deserializer #(.LENGTH(LENGTH)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (i_en),
    .i_start     (i_start),
    .i_din       (i_din),
    .ov_dout     (ov_dout),
    .o_dout_valid(o_dout_valid),
    .o_busy      (o_busy),
    .o_abort     (o_abort)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  bit                frame_bits[$];
  logic [LENGTH-1:0] exp_word_q[$];
  int                exp_wcyc_q[$];
  int                exp_abort_q[$];
  logic [LENGTH-1:0] exp_dout = '0;
  logic              exp_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus plus the model's view of what that edge does.
  task automatic send(input logic en, input logic st, input logic d);
    logic [LENGTH-1:0] w;
    i_en = en; i_start = st; i_din = d;
    @(posedge i_clk);
    #1;
    if (en) begin
      if (st) begin
        if (frame_bits.size() > 0) exp_abort_q.push_back(cyc);
        frame_bits.delete();
        frame_bits.push_back(d);
      end else if (frame_bits.size() > 0) begin
        frame_bits.push_back(d);
      end
      if (frame_bits.size() == LENGTH) begin
        w = '0;
        for (int i = 0; i < LENGTH; i++) w = w + (LENGTH'(frame_bits[i]) << i);
        exp_word_q.push_back(w);
        exp_wcyc_q.push_back(cyc);
        exp_dout = w;
        frame_bits.delete();
      end
      exp_busy = (frame_bits.size() > 0);
    end
  endtask

  task automatic send_word(input logic [LENGTH-1:0] w, input int stall_at, input int stall_len);
    for (int i = 0; i < LENGTH; i++) begin
      if (i == stall_at)
        for (int s = 0; s < stall_len; s++) send(1'b0, 1'($urandom), 1'($urandom));
      send(1'b1, (i == 0), w[i]);
    end
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) send(1'b1, (i == 0), 1'($urandom));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b1, 1'b0, 1'($urandom));
  endtask

  // Monitor: pops expectations whenever the DUT pulses, flags missed pulses.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_dout_valid) begin
        if (exp_word_q.size() == 0) begin
          check("unexpected_valid", 64'(o_dout_valid), 64'd0);
        end else begin
          check("word", 64'(ov_dout), 64'(exp_word_q.pop_front()));
          check("valid_cycle", 64'(cyc), 64'(exp_wcyc_q.pop_front()));
        end
      end else if (exp_wcyc_q.size() > 0 && exp_wcyc_q[0] <= cyc) begin
        check("missed_valid", 64'(o_dout_valid), 64'd1);
        void'(exp_word_q.pop_front());
        void'(exp_wcyc_q.pop_front());
      end
      if (o_abort) begin
        if (exp_abort_q.size() == 0) check("unexpected_abort", 64'(o_abort), 64'd0);
        else check("abort_cycle", 64'(cyc), 64'(exp_abort_q.pop_front()));
      end else if (exp_abort_q.size() > 0 && exp_abort_q[0] <= cyc) begin
        check("missed_abort", 64'(o_abort), 64'd1);
        void'(exp_abort_q.pop_front());
      end
      check("busy", 64'(o_busy), 64'(exp_busy));
      check("dout_hold", 64'(ov_dout), 64'(exp_dout));
    end
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_dout", 64'(ov_dout), 64'd0);
    check("rst_valid", 64'(o_dout_valid), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_abort", 64'(o_abort), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle(2);

    // T1 single word.
    send_word(24'hA5C3F0, -1, 0);
    idle(2);
    // T2 back-to-back words, no idle bits between.
    send_word(24'h000001, -1, 0);
    send_word(24'h800000, -1, 0);
    idle(2);
    // T3 stall for 5 cycles after bit 10.
    send_word(24'h123456, 11, 5);
    idle(2);
    // T4 restart at bit 12, then a full word.
    send_partial(12);
    send_word(24'hFFFFFF, -1, 0);
    idle(2);

    // T5 asynchronous reset in the middle of a frame.
    send_partial(7);
    i_en = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    check("async_rst_dout", 64'(ov_dout), 64'd0);
    check("async_rst_busy", 64'(o_busy), 64'd0);
    check("async_rst_valid", 64'(o_dout_valid), 64'd0);
    check("async_rst_abort", 64'(o_abort), 64'd0);
    frame_bits.delete();
    exp_busy = 1'b0;
    exp_dout = '0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle(1);
    send_word(24'h00BEEF, -1, 0);
    idle(2);

    // T6 100 random words with random gaps, stalls and occasional restarts.
    for (int n = 0; n < 100; n++) begin
      if ($urandom_range(0, 19) == 0) send_partial($urandom_range(1, LENGTH - 1));
      send_word(LENGTH'($urandom), $urandom_range(0, 40), $urandom_range(1, 4));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(3);

    check("pending_words", 64'(exp_word_q.size()), 64'd0);
    check("pending_aborts", 64'(exp_abort_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
